// File: rtl/shift_ex_stage.sv
// Execute-stage shift unit: SLL/SRL/SRA log shifters into a 2-entry skid buffer.
// Define SHIFT_EX_ZBB_EN to make ROL/ROR legal; otherwise they are reserved ops.
module shift_ex_stage #(
    parameter int TAG_W   = 5,
    parameter int SHAMT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [31:0]      i_a,
    input  logic [31:0]      i_b,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_result,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_illegal
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
`ifdef SHIFT_EX_ZBB_EN
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
`endif

    logic [SHAMT_W-1:0] shamt;
    logic               fill;
    logic               unused_b;

    assign shamt    = i_b[SHAMT_W-1:0];
    assign fill     = (i_op == OP_SRA) & i_a[31];
    assign unused_b = ^i_b[31:SHAMT_W];

    // One left tree for SLL; one right tree shared by SRL/SRA via the fill bit.
    logic [31:0] sl_lvl [SHAMT_W+1];
    logic [31:0] sr_lvl [SHAMT_W+1];

    assign sl_lvl[0] = i_a;
    assign sr_lvl[0] = i_a;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_shift
        localparam int W = 1 << k;
        assign sl_lvl[k+1] = shamt[k] ? {sl_lvl[k][31-W:0], {W{1'b0}}}
                                      : sl_lvl[k];
        assign sr_lvl[k+1] = shamt[k] ? {{W{fill}}, sr_lvl[k][31:W]}
                                      : sr_lvl[k];
    end

`ifdef SHIFT_EX_ZBB_EN
    // ROR by s is ROL by (32 - s) mod 32, so a single rotate tree serves both.
    logic [SHAMT_W-1:0] rot_amt;
    logic [31:0]        rl_lvl [SHAMT_W+1];

    assign rot_amt   = (i_op == OP_ROR) ? (SHAMT_W'(0) - shamt) : shamt;
    assign rl_lvl[0] = i_a;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_rot
        localparam int W = 1 << k;
        assign rl_lvl[k+1] = rot_amt[k] ? {rl_lvl[k][31-W:0], rl_lvl[k][31:32-W]}
                                        : rl_lvl[k];
    end
`endif

    logic [31:0] calc_result;
    logic        calc_illegal;

    always_comb begin
        calc_result  = '0;
        calc_illegal = 1'b0;
        case (i_op)
            OP_SLL: calc_result = sl_lvl[SHAMT_W];
            OP_SRL: calc_result = sr_lvl[SHAMT_W];
            OP_SRA: calc_result = sr_lvl[SHAMT_W];
`ifdef SHIFT_EX_ZBB_EN
            OP_ROL: calc_result = rl_lvl[SHAMT_W];
            OP_ROR: calc_result = rl_lvl[SHAMT_W];
`endif
            default: calc_illegal = 1'b1;
        endcase
    end

    logic             m_valid;
    logic [31:0]      m_result;
    logic [TAG_W-1:0] m_tag;
    logic             m_illegal;

    logic             s_valid;
    logic [31:0]      s_result;
    logic [TAG_W-1:0] s_tag;
    logic             s_illegal;

    logic accept;
    logic main_free;

    // o_ready comes straight from the skid flop, never from i_ready.
    assign o_ready   = !s_valid;
    assign accept    = i_valid && o_ready;
    assign main_free = !m_valid || i_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            m_valid   <= 1'b0;
            m_result  <= '0;
            m_tag     <= '0;
            m_illegal <= 1'b0;
            s_valid   <= 1'b0;
            s_result  <= '0;
            s_tag     <= '0;
            s_illegal <= 1'b0;
        end else if (i_flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (main_free) begin
            if (s_valid) begin
                m_valid   <= 1'b1;
                m_result  <= s_result;
                m_tag     <= s_tag;
                m_illegal <= s_illegal;
                s_valid   <= 1'b0;
            end else if (accept) begin
                m_valid   <= 1'b1;
                m_result  <= calc_result;
                m_tag     <= i_tag;
                m_illegal <= calc_illegal;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            s_valid   <= 1'b1;
            s_result  <= calc_result;
            s_tag     <= i_tag;
            s_illegal <= calc_illegal;
        end
    end

    assign o_valid   = m_valid;
    assign o_result  = m_result;
    assign o_tag     = m_tag;
    assign o_illegal = m_illegal;

endmodule

// File: tb/tb_shift_ex_stage.sv
// Directed bench for shift_ex_stage: datapath, skid buffer, flush, reset.
// Honours SHIFT_EX_ZBB_EN for the rotate expectations.
module tb_shift_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready_o;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  out_tag;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_ex_stage #(.TAG_W(5), .SHAMT_W(5)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_flush   (flush),
        .i_valid   (in_valid),
        .o_ready   (in_ready_o),
        .i_op      (op),
        .i_a       (a),
        .i_b       (b),
        .i_tag     (tag),
        .o_valid   (out_valid),
        .i_ready   (out_ready),
        .o_result  (result),
        .o_tag     (out_tag),
        .o_illegal (illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [4:0] t);
        in_valid = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
        tag      = t;
    endtask

    task automatic out_chk(input string name, input logic [31:0] r,
                           input logic [4:0] t, input logic ill);
        chk({name, ".valid"}, 32'(out_valid), 32'd1);
        chk({name, ".result"}, result, r);
        chk({name, ".tag"}, 32'(out_tag), 32'(t));
        chk({name, ".illegal"}, 32'(illegal), 32'(ill));
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'b000;
        a         = '0;
        b         = '0;
        tag       = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.result", result, 32'h0);
        chk("rst.tag", 32'(out_tag), 32'd0);
        chk("rst.illegal", 32'(illegal), 32'd0);
        chk("rst.ready", 32'(in_ready_o), 32'd1);

        // Basic datapath, one op per cycle with downstream ready
        drive(3'b000, 32'h0000_0001, 32'd31, 5'd3);
        tick();
        out_chk("sll31", 32'h8000_0000, 5'd3, 1'b0);
        drive(3'b010, 32'h8000_0000, 32'd4, 5'd4);
        tick();
        out_chk("sra4", 32'hF800_0000, 5'd4, 1'b0);
        drive(3'b001, 32'h8000_0000, 32'd4, 5'd5);
        tick();
        out_chk("srl4", 32'h0800_0000, 5'd5, 1'b0);
        drive(3'b010, 32'h7FFF_FFF0, 32'h25, 5'd6);
        tick();
        out_chk("sra_hib", 32'h03FF_FFFF, 5'd6, 1'b0);
        drive(3'b000, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 5'd7);
        tick();
        out_chk("sll0", 32'hDEAD_BEEF, 5'd7, 1'b0);
        drive(3'b001, 32'hFFFF_FFFF, 32'd31, 5'd8);
        tick();
        out_chk("srl31", 32'h0000_0001, 5'd8, 1'b0);
        drive(3'b111, 32'h1234_5678, 32'd3, 5'd9);
        tick();
        out_chk("resv", 32'h0, 5'd9, 1'b1);
        in_valid = 1'b0;
        tick();
        chk("idle.valid", 32'(out_valid), 32'd0);

        // Back-to-back under stall: A to main, B to skid, C held off
        out_ready = 1'b0;
        drive(3'b000, 32'h3, 32'd2, 5'd1);
        tick();
        out_chk("stA", 32'hC, 5'd1, 1'b0);
        chk("stA.ready", 32'(in_ready_o), 32'd1);
        drive(3'b001, 32'h100, 32'd4, 5'd2);
        tick();
        out_chk("stB.hold", 32'hC, 5'd1, 1'b0);
        chk("stB.ready", 32'(in_ready_o), 32'd0);
        drive(3'b010, 32'hFFFF_FF00, 32'd8, 5'd3);
        tick();
        out_chk("stC.hold", 32'hC, 5'd1, 1'b0);
        chk("stC.ready", 32'(in_ready_o), 32'd0);
        out_ready = 1'b1;
        tick();
        out_chk("drB", 32'h10, 5'd2, 1'b0);
        chk("drB.ready", 32'(in_ready_o), 32'd1);
        tick();
        out_chk("drC", 32'hFFFF_FFFF, 5'd3, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("drain.empty", 32'(out_valid), 32'd0);

        // Flush with both entries held and a new op offered
        out_ready = 1'b0;
        drive(3'b000, 32'h1, 32'd1, 5'd10);
        tick();
        drive(3'b000, 32'h1, 32'd2, 5'd11);
        tick();
        chk("fl.full", 32'(in_ready_o), 32'd0);
        flush = 1'b1;
        drive(3'b000, 32'h1, 32'd3, 5'd12);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("fl.valid", 32'(out_valid), 32'd0);
        chk("fl.ready", 32'(in_ready_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl.quiet", 32'(out_valid), 32'd0);
        end

        // Rotates: legal only with the Zbb option compiled in
        drive(3'b100, 32'h0000_0001, 32'd1, 5'd13);
        tick();
`ifdef SHIFT_EX_ZBB_EN
        out_chk("ror1", 32'h8000_0000, 5'd13, 1'b0);
`else
        out_chk("ror1", 32'h0, 5'd13, 1'b1);
`endif
        drive(3'b011, 32'h8000_0001, 32'd4, 5'd14);
        tick();
`ifdef SHIFT_EX_ZBB_EN
        out_chk("rol4", 32'h0000_0018, 5'd14, 1'b0);
`else
        out_chk("rol4", 32'h0, 5'd14, 1'b1);
`endif
        in_valid = 1'b0;
        tick();

        // Reset while main is stalled and another op is offered
        out_ready = 1'b0;
        drive(3'b000, 32'h5, 32'd1, 5'd15);
        tick();
        out_chk("pre_rst", 32'hA, 5'd15, 1'b0);
        rst = 1'b1;
        drive(3'b000, 32'h7, 32'd1, 5'd16);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mrst.valid", 32'(out_valid), 32'd0);
        chk("mrst.result", result, 32'h0);
        chk("mrst.tag", 32'(out_tag), 32'd0);
        chk("mrst.illegal", 32'(illegal), 32'd0);
        chk("mrst.ready", 32'(in_ready_o), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("mrst.quiet", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_ex_stage.md
Name: shift_ex_stage

Overview:
- Execute-stage shift unit for the pipelined core.
- Accepts decoded shift micro-ops from the ID/EX path over a valid/ready handshake.
- Computes SLL/SRL/SRA using the team's 32-bit log shifters (5-level mux trees).
- Registers the result with a destination tag into a 2-entry skid buffer feeding the EX/MEM writeback mux.
- Isolates shifter combinational depth from downstream stalls.

Parameters:
TAG_W, 5, width of destination-register tag carried alongside the result
SHAMT_W, 5, shift-amount width; fixed for 32-bit data, only 5 is supported

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_reset  input  1  synchronous active-high reset
i_flush  input  1  pipeline flush: kill all held entries
i_valid  input  1  upstream micro-op valid
o_ready  output  1  stage can accept a micro-op this cycle
i_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others reserved
i_a  input  32  data operand
i_b  input  32  shift-amount source; only bits [4:0] are used
i_tag  input  TAG_W  destination tag
o_valid  output  1  result valid to downstream
i_ready  input  1  downstream accepts the result
o_result  output  32  shift result
o_tag  output  TAG_W  tag of o_result
o_illegal  output  1  qualifies o_valid: op was reserved or disabled

Behaviour:
Reset and clocking:
- One clock. Reset is synchronous, active-high.
- Reset values: o_valid=0, o_result=0, o_tag=0, o_illegal=0, both skid entries empty, o_ready=1 in the first cycle after reset.

Datapath:
- Result is computed combinationally from i_a and i_b[4:0].
- SLL and SRL zero-fill. SRA replicates i_a[31].
- A shift amount of 0 returns i_a unchanged.
- i_b[31:5] are ignored.

Skid buffer:
- Two entries: main (drives the outputs) and skid.
- Accept when i_valid && o_ready.
- o_ready = !skid_full. It is a registered signal with no combinational path from i_ready.

Latency and ordering:
- Latency 1: an accepted op appears on o_* on the next edge when main is empty, or when main is draining (o_valid && i_ready) that same cycle.
- If main holds and is stalled (o_valid && !i_ready), the accepted op goes to skid and o_ready drops next cycle.
- On drain with skid full, skid moves to main and o_ready returns to 1 the cycle after.
- Accept and drain in the same cycle with main full and skid empty: the new op replaces main. Throughput is 1 op/cycle.
- Order is strictly preserved. No op is dropped or duplicated.

Output stability:
- While o_valid && !i_ready, o_result/o_tag/o_illegal hold stable.

Reserved ops:
- Result 0, o_illegal=1, the op still flows through the handshake.

Flush:
- i_flush clears main and skid next edge: o_valid=0, o_ready=1.
- A simultaneous i_valid is discarded.
- Reset has priority over flush.

Reset mid-operation:
- Reset while entries are held discards them.
- No output is produced for discarded ops.

Optional Feature:
SHIFT_EX_ZBB_EN
- Defined: ops 011 ROL and 100 ROR are legal.
  - ROL: (i_a << s) | (i_a >> (32-s)).
  - ROR: the mirror of ROL.
  - s=0 returns i_a.
- Undefined: ROL and ROR are reserved. They produce result 0 with o_illegal=1.
- No rotate logic is synthesized when the macro is undefined.

Test Plan:
1. Reset, then SLL a=0x00000001 b=31, i_ready=1 -> next cycle o_valid=1, o_result=0x80000000, o_tag echoed, o_illegal=0.
2. SRA a=0x80000000 b=4 -> 0xF8000000; SRL with the same operands -> 0x08000000; SRA a=0x7FFFFFF0 b=0x25 (uses 5) -> 0x03FFFFFF.
3. Hold i_ready=0 and issue 3 back-to-back ops:
   - the first two are accepted;
   - o_ready=0 from the 3rd cycle;
   - o_* stays stable;
   - releasing i_ready drains results in issue order with no gaps.
4. Two entries held, assert i_flush with i_valid=1 -> next cycle o_valid=0, o_ready=1, and nothing appears later.
5. op=100 ROR a=0x00000001 b=1:
   - with SHIFT_EX_ZBB_EN -> 0x80000000, o_illegal=0;
   - without -> 0x00000000, o_illegal=1.
6. Assert i_reset while main is stalled with i_valid=1 -> next cycle all outputs at reset values and the pending op is lost.
